bt_cmd_parser: RTL and testbench

Byte-stream command decoder that sits directly downstream of the UART RS232 receiver on the HC-06 Bluetooth link. It consumes each received byte (RxData qualified by RxDone), assembles framed command packets, validates length and checksum, and presents one decoded command per valid frame to the control logic. Malformed, truncated or stalled frames are dropped and reported with an error code.

---
 rtl/bt_pkg.sv | 21 ++
 rtl/edge_rise.sv | 21 ++
 rtl/bt_cmd_parser.sv | 129 ++++++++++++
 tb/tb_bt_cmd_parser.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth command parser: FSM encoding, error codes, defaults.
package bt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CSUM
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] HEADER_DEFAULT  = 8'hAA;
    localparam int         MAX_LEN_DEFAULT = 4;
    localparam int         TIMEOUT_DEFAULT = 250000;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector with a registered one-cycle pulse output.
module edge_rise (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= 1'b0;
            o_rise <= 1'b0;
        end else begin
            r_prev <= i_sig;
            o_rise <= i_sig & ~r_prev;
        end
    end

endmodule

// File: rtl/bt_cmd_parser.sv
// Framed command decoder for the UART byte stream: HEADER, CMD, LEN, payload, XOR checksum.
// state     | meaning
// S_IDLE    | hunting for HEADER, other bytes ignored
// S_CMD     | next byte is the command code
// S_LEN     | next byte is the payload length
// S_PAYLOAD | collecting payload bytes
// S_CSUM    | next byte is the checksum
module bt_cmd_parser
    import bt_pkg::*;
#(
    parameter logic [7:0] HEADER  = HEADER_DEFAULT,
    parameter int         MAX_LEN = MAX_LEN_DEFAULT,
    parameter int         TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [7:0]           RxData,
    input  logic                 RxDone,
    output logic                 CmdValid,
    output logic [7:0]           CmdCode,
    output logic [2:0]           CmdLen,
    output logic [8*MAX_LEN-1:0] CmdPayload,
    output logic                 CmdErr,
    output logic [1:0]           ErrCode
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic                 w_strobe;
    logic                 w_timeout;
    state_t               r_state;
    logic [7:0]           r_code;
    logic [7:0]           r_xor;
    logic [2:0]           r_len;
    logic [2:0]           r_idx;
    logic [8*MAX_LEN-1:0] r_shadow;
    logic [CNT_W-1:0]     r_cnt;

    edge_rise u_rx_edge (
        .i_clk  (Clk),
        .i_rst  (Rst),
        .i_sig  (RxDone),
        .o_rise (w_strobe)
    );

    assign w_timeout = (r_state != S_IDLE) && (r_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE || w_strobe || w_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_code     <= '0;
            r_xor      <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_shadow   <= '0;
            CmdValid   <= 1'b0;
            CmdCode    <= '0;
            CmdLen     <= '0;
            CmdPayload <= '0;
            CmdErr     <= 1'b0;
            ErrCode    <= ERR_NONE;
        end else begin
            CmdValid <= 1'b0;
            CmdErr   <= 1'b0;
            // A byte arriving in the timeout cycle wins over the timeout.
            if (w_strobe) begin
                case (r_state)
                    S_IDLE: begin
                        if (RxData == HEADER) r_state <= S_CMD;
                    end
                    S_CMD: begin
                        r_code  <= RxData;
                        r_xor   <= RxData;
                        r_state <= S_LEN;
                    end
                    S_LEN: begin
                        if (RxData > 8'(MAX_LEN)) begin
                            CmdErr  <= 1'b1;
                            ErrCode <= ERR_LEN;
                            r_state <= S_IDLE;
                        end else begin
                            r_len    <= RxData[2:0];
                            r_xor    <= r_xor ^ RxData;
                            r_shadow <= '0;
                            r_idx    <= '0;
                            r_state  <= (RxData == 8'd0) ? S_CSUM : S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (r_idx == 3'(i)) r_shadow[8*i +: 8] <= RxData;
                        end
                        r_xor <= r_xor ^ RxData;
                        r_idx <= r_idx + 3'd1;
                        if ((r_idx + 3'd1) == r_len) r_state <= S_CSUM;
                    end
                    S_CSUM: begin
                        if (RxData == r_xor) begin
                            CmdValid   <= 1'b1;
                            CmdCode    <= r_code;
                            CmdLen     <= r_len;
                            CmdPayload <= r_shadow;
                        end else begin
                            CmdErr  <= 1'b1;
                            ErrCode <= ERR_CSUM;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (w_timeout) begin
                CmdErr  <= 1'b1;
                ErrCode <= ERR_TIMEOUT;
                r_state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_bt_cmd_parser.sv
// Self-checking bench for bt_cmd_parser: frame vector table plus timeout, priority and reset sequences.
module tb_bt_cmd_parser;

    localparam int TMO = 40;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  RxData;
    logic        RxDone;
    logic        CmdValid;
    logic [7:0]  CmdCode;
    logic [2:0]  CmdLen;
    logic [31:0] CmdPayload;
    logic        CmdErr;
    logic [1:0]  ErrCode;

    bt_cmd_parser #(.HEADER(8'hAA), .MAX_LEN(4), .TIMEOUT(TMO)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .RxData     (RxData),
        .RxDone     (RxDone),
        .CmdValid   (CmdValid),
        .CmdCode    (CmdCode),
        .CmdLen     (CmdLen),
        .CmdPayload (CmdPayload),
        .CmdErr     (CmdErr),
        .ErrCode    (ErrCode)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_both  = 0;
    logic last_valid, last_err;

    always @(negedge Clk) begin
        if (CmdValid) n_valid++;
        if (CmdErr) n_err++;
        if (CmdValid && CmdErr) n_both++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse RxDone for two cycles; captures the pulse outputs at the expected latency.
    task automatic send_byte(input logic [7:0] b);
        @(negedge Clk);
        RxData = b;
        RxDone = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        RxDone = 1'b0;
        last_valid = CmdValid;
        last_err   = CmdErr;
        @(negedge Clk);
    endtask

    typedef struct {
        logic [63:0] bytes;
        int          n;
        logic        ev;
        logic        ee;
        logic [1:0]  ec;
        logic [7:0]  code;
        logic [2:0]  len;
        logic [31:0] pl;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bv, be;
        logic [63:0] bb;

        vecs[0] = '{64'hAA10023456700000, 6, 1'b1, 1'b0, 2'd0, 8'h10, 3'd2, 32'h00005634};
        vecs[1] = '{64'hAA05000500000000, 4, 1'b1, 1'b0, 2'd0, 8'h05, 3'd0, 32'h00000000};
        vecs[2] = '{64'hAA1001FF00000000, 5, 1'b0, 1'b1, 2'd2, 8'h05, 3'd0, 32'h00000000};
        vecs[3] = '{64'hAA10070000000000, 3, 1'b0, 1'b1, 2'd1, 8'h05, 3'd0, 32'h00000000};
        vecs[4] = '{64'hAA05000500000000, 4, 1'b1, 1'b0, 2'd1, 8'h05, 3'd0, 32'h00000000};
        vecs[5] = '{64'h1234000000000000, 2, 1'b0, 1'b0, 2'd1, 8'h05, 3'd0, 32'h00000000};
        vecs[6] = '{64'hAAAA04AA01020304, 8, 1'b1, 1'b0, 2'd1, 8'hAA, 3'd4, 32'h030201AA};
        vecs[7] = '{64'hAA20050000000000, 3, 1'b0, 1'b1, 2'd1, 8'hAA, 3'd4, 32'h030201AA};
        vecs[8] = '{64'h12AA210155750000, 6, 1'b1, 1'b0, 2'd1, 8'h21, 3'd1, 32'h00000055};

        Rst = 1'b1;
        RxDone = 1'b0;
        RxData = 8'h00;
        repeat (3) @(negedge Clk);
        chk("reset_valid", {31'd0, CmdValid}, 32'd0);
        chk("reset_err", {31'd0, CmdErr}, 32'd0);
        chk("reset_code", {24'd0, CmdCode}, 32'd0);
        chk("reset_payload", CmdPayload, 32'd0);
        chk("reset_errcode", {30'd0, ErrCode}, 32'd0);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        for (int v = 0; v < 9; v++) begin
            bv = n_valid;
            be = n_err;
            bb = vecs[v].bytes;
            for (int k = 0; k < vecs[v].n; k++) send_byte(bb[63-8*k -: 8]);
            repeat (3) @(negedge Clk);
            chk($sformatf("v%0d_valid_at_latency", v), {31'd0, last_valid}, {31'd0, vecs[v].ev});
            chk($sformatf("v%0d_err_at_latency", v), {31'd0, last_err}, {31'd0, vecs[v].ee});
            chk($sformatf("v%0d_valid_count", v), n_valid - bv, {31'd0, vecs[v].ev});
            chk($sformatf("v%0d_err_count", v), n_err - be, {31'd0, vecs[v].ee});
            chk($sformatf("v%0d_errcode", v), {30'd0, ErrCode}, {30'd0, vecs[v].ec});
            chk($sformatf("v%0d_code", v), {24'd0, CmdCode}, {24'd0, vecs[v].code});
            chk($sformatf("v%0d_len", v), {29'd0, CmdLen}, {29'd0, vecs[v].len});
            chk($sformatf("v%0d_payload", v), CmdPayload, vecs[v].pl);
        end

        // RxDone held high across many cycles must count as one HEADER byte.
        bv = n_valid;
        be = n_err;
        @(negedge Clk);
        RxData = 8'hAA;
        RxDone = 1'b1;
        repeat (8) @(negedge Clk);
        RxDone = 1'b0;
        @(negedge Clk);
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h05);
        repeat (2) @(negedge Clk);
        chk("held_valid", {31'd0, last_valid}, 32'd1);
        chk("held_valid_count", n_valid - bv, 32'd1);
        chk("held_err_count", n_err - be, 32'd0);
        chk("held_code", {24'd0, CmdCode}, 32'h05);

        // Stall after AA 10: error exactly TIMEOUT+1 cycles after the last strobe.
        be = n_err;
        bv = n_valid;
        send_byte(8'hAA);
        send_byte(8'h10);
        repeat (TMO - 1) @(negedge Clk);
        chk("tmo_not_early", {31'd0, CmdErr}, 32'd0);
        @(negedge Clk);
        chk("tmo_fires", {31'd0, CmdErr}, 32'd1);
        chk("tmo_errcode", {30'd0, ErrCode}, 32'd3);
        @(negedge Clk);
        chk("tmo_one_cycle", {31'd0, CmdErr}, 32'd0);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (TMO + 5) @(negedge Clk);
        chk("tmo_err_count", n_err - be, 32'd1);
        chk("tmo_valid_count", n_valid - bv, 32'd0);
        chk("tmo_code_kept", {24'd0, CmdCode}, 32'h05);

        // A strobe landing in the timeout cycle is processed instead of timing out.
        be = n_err;
        bv = n_valid;
        send_byte(8'hAA);
        send_byte(8'h10);
        repeat (TMO - 3) @(negedge Clk);
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h70);
        repeat (2) @(negedge Clk);
        chk("prio_valid", {31'd0, last_valid}, 32'd1);
        chk("prio_err_count", n_err - be, 32'd0);
        chk("prio_valid_count", n_valid - bv, 32'd1);
        chk("prio_payload", CmdPayload, 32'h00005634);

        // Reset mid-frame clears everything at once and drops the partial frame.
        bv = n_valid;
        be = n_err;
        send_byte(8'hAA);
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h34);
        Rst = 1'b1;
        #1;
        chk("rst_code", {24'd0, CmdCode}, 32'd0);
        chk("rst_len", {29'd0, CmdLen}, 32'd0);
        chk("rst_payload", CmdPayload, 32'd0);
        chk("rst_errcode", {30'd0, ErrCode}, 32'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_no_pulse", (n_valid - bv) + (n_err - be), 32'd0);
        send_byte(8'hAA);
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h70);
        repeat (2) @(negedge Clk);
        chk("post_rst_valid", {31'd0, last_valid}, 32'd1);
        chk("post_rst_code", {24'd0, CmdCode}, 32'h10);
        chk("post_rst_len", {29'd0, CmdLen}, 32'd2);
        chk("post_rst_payload", CmdPayload, 32'h00005634);
        chk("post_rst_err_count", n_err - be, 32'd0);

        chk("never_both_high", n_both, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
